// File: rtl/sevseg_pkg.sv
// Shared segment encodings and the nibble-to-segment lookup for the scanned 7-segment driver.
// Segment vectors are active-low, ordered a..g from bit 6 down to bit 0.
package sevseg_pkg;

    localparam logic [6:0] SEG_0     = 7'b000_0001;
    localparam logic [6:0] SEG_1     = 7'b100_1111;
    localparam logic [6:0] SEG_2     = 7'b001_0010;
    localparam logic [6:0] SEG_3     = 7'b000_0110;
    localparam logic [6:0] SEG_4     = 7'b100_1100;
    localparam logic [6:0] SEG_5     = 7'b010_0100;
    localparam logic [6:0] SEG_6     = 7'b010_0000;
    localparam logic [6:0] SEG_7     = 7'b000_1111;
    localparam logic [6:0] SEG_8     = 7'b000_0000;
    localparam logic [6:0] SEG_9     = 7'b000_1100;
    localparam logic [6:0] SEG_A     = 7'b000_1000;
    localparam logic [6:0] SEG_B     = 7'b110_0000;
    localparam logic [6:0] SEG_C     = 7'b011_0001;
    localparam logic [6:0] SEG_D     = 7'b100_0010;
    localparam logic [6:0] SEG_E     = 7'b011_0000;
    localparam logic [6:0] SEG_F     = 7'b011_1000;
    localparam logic [6:0] SEG_BLANK = 7'b111_1111;

    function automatic logic [6:0] nibble_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/sevseg_hex_decode.sv
// Combinational hex nibble to active-low 7-segment pattern lookup.
module sevseg_hex_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    assign seg_o = nibble_to_seg(nibble_i);

endmodule

// File: rtl/sevseg_scan_driver.sv
// Multiplexed N-digit hex display scanner with frame-synchronous loading and leading-zero blanking.
// Optional decimal points are compiled in when SEVSEG_DP_EN is defined.
module sevseg_scan_driver
    import sevseg_pkg::*;
#(
    parameter int N_DIGITS       = 4,
    parameter int REFRESH_CYCLES = 100000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] value,
    input  logic                  load,
    input  logic                  blank_lz,
    input  logic                  enable,
`ifdef SEVSEG_DP_EN
    input  logic [N_DIGITS-1:0]   dp_in,
    output logic                  dp,
`endif
    output logic [6:0]            seg,
    output logic [N_DIGITS-1:0]   digit,
    output logic                  frame_tick
);

    localparam int TIMER_W = $clog2(REFRESH_CYCLES);
    localparam int IDX_W   = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(REFRESH_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(N_DIGITS - 1);

    logic [TIMER_W-1:0]    timer_q, timer_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] pending_q, pending_d;
    logic [4*N_DIGITS-1:0] shadow_q, shadow_d;
    logic [6:0]            seg_q, seg_d;
    logic [N_DIGITS-1:0]   digit_q, digit_d;
    logic                  frame_tick_q, frame_tick_d;

    logic                  terminal;
    logic                  frame_end;
    logic                  lit;
    logic [3:0]            shadow_nib [N_DIGITS];
    logic [N_DIGITS-1:0]   lz_blank;
    logic [6:0]            cur_seg;

    // lz_blank[i]: this digit and every more-significant digit are zero.
    for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_nib
        assign shadow_nib[gi] = shadow_q[4*gi +: 4];
        assign lz_blank[gi]   = (shadow_q[4*N_DIGITS-1 : 4*gi] == '0);
    end

    sevseg_hex_decode u_decode (
        .nibble_i (shadow_nib[idx_q]),
        .seg_o    (cur_seg)
    );

    assign terminal  = (timer_q == TIMER_LAST);
    assign frame_end = terminal && (idx_q == IDX_LAST);
    assign lit       = enable && !(blank_lz && (idx_q != '0) && lz_blank[idx_q]);

    always_comb begin
        timer_d      = terminal ? '0 : timer_q + 1'b1;
        idx_d        = idx_q;
        pending_d    = load ? value : pending_q;
        shadow_d     = shadow_q;
        seg_d        = SEG_BLANK;
        digit_d      = '1;
        frame_tick_d = (timer_q == '0) && (idx_q == '0);
        if (terminal) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
        // A load landing on the boundary bypasses pending so it is not lost for a frame.
        if (frame_end) begin
            shadow_d = load ? value : pending_q;
        end
        if (lit) begin
            seg_d   = cur_seg;
            digit_d = ~(N_DIGITS'(1) << idx_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timer_q      <= '0;
            idx_q        <= '0;
            pending_q    <= '0;
            shadow_q     <= '0;
            seg_q        <= SEG_BLANK;
            digit_q      <= '1;
            frame_tick_q <= 1'b0;
        end else begin
            timer_q      <= timer_d;
            idx_q        <= idx_d;
            pending_q    <= pending_d;
            shadow_q     <= shadow_d;
            seg_q        <= seg_d;
            digit_q      <= digit_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign seg        = seg_q;
    assign digit      = digit_q;
    assign frame_tick = frame_tick_q;

`ifdef SEVSEG_DP_EN
    logic [N_DIGITS-1:0] pending_dp_q, pending_dp_d;
    logic [N_DIGITS-1:0] shadow_dp_q, shadow_dp_d;
    logic                dp_q, dp_d;

    always_comb begin
        pending_dp_d = load ? dp_in : pending_dp_q;
        shadow_dp_d  = shadow_dp_q;
        dp_d         = 1'b1;
        if (frame_end) begin
            shadow_dp_d = load ? dp_in : pending_dp_q;
        end
        if (lit) begin
            dp_d = ~shadow_dp_q[idx_q];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending_dp_q <= '0;
            shadow_dp_q  <= '0;
            dp_q         <= 1'b1;
        end else begin
            pending_dp_q <= pending_dp_d;
            shadow_dp_q  <= shadow_dp_d;
            dp_q         <= dp_d;
        end
    end

    assign dp = dp_q;
`endif

endmodule

// File: tb/tb_sevseg_scan_driver.sv
// Directed self-checking bench for sevseg_scan_driver with N_DIGITS=4, REFRESH_CYCLES=4.
// cyc counts rising edges since reset release (first edge = 0); outputs are sampled on the falling edge.
module tb_sevseg_scan_driver;

    localparam int N = 4;
    localparam int R = 4;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0001100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic        load;
    logic        blank_lz;
    logic        enable;
    logic [6:0]  seg;
    logic [3:0]  digit;
    logic        frame_tick;
`ifdef SEVSEG_DP_EN
    logic [3:0]  dp_in;
    logic        dp;
`endif

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    sevseg_scan_driver #(
        .N_DIGITS       (N),
        .REFRESH_CYCLES (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .load       (load),
        .blank_lz   (blank_lz),
        .enable     (enable),
`ifdef SEVSEG_DP_EN
        .dp_in      (dp_in),
        .dp         (dp),
`endif
        .seg        (seg),
        .digit      (digit),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; load = 1'b0; blank_lz = 1'b0; value = 16'h0;
`ifdef SEVSEG_DP_EN
        dp_in = 4'h0;
`endif
        repeat (3) tick();
        tests++;
        if (seg !== 7'b1111111 || digit !== 4'b1111 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL reset: seg=%b digit=%b tick=%b, required seg=1111111 digit=1111 tick=0",
                     seg, digit, frame_tick);
        end
`ifdef SEVSEG_DP_EN
        tests++;
        if (dp !== 1'b1) begin
            fails++;
            $display("FAIL reset_dp: dp=%b, required 1", dp);
        end
`endif
        rst = 1'b0;
        cyc = -1;
        $display("[TB] reset checked");
    endtask

    task automatic test_scan();
        int d;
        logic [3:0] exp_dig;
        for (int n = 0; n < 32; n++) begin
            tick();
            d = (cyc / 4) % 4;
            exp_dig = ~(4'b0001 << d);
            tests++;
            if (digit !== exp_dig || seg !== 7'b0000001 || frame_tick !== (cyc % 16 == 0)) begin
                fails++;
                $display("FAIL scan cyc=%0d: digit=%b seg=%b tick=%b, required digit=%b seg=0000001 tick=%b",
                         cyc, digit, seg, frame_tick, exp_dig, (cyc % 16 == 0));
            end
        end
        $display("[TB] scan checked through cyc %0d", cyc);
    endtask

    task automatic test_load();
        int d;
        logic [15:0] exp_val;
        logic [3:0]  exp_dig, nib;
        logic [6:0]  exp_seg;
        value = 16'h12AF; load = 1'b1;
        for (int n = 0; n < 32; n++) begin
            tick();
            load = 1'b0;
            exp_val = (cyc < 48) ? 16'h0000 : 16'h12AF;
            d = (cyc / 4) % 4;
            nib = 4'(exp_val >> (4 * d));
            exp_dig = ~(4'b0001 << d);
            exp_seg = SEG_TAB[nib];
            tests++;
            if (digit !== exp_dig || seg !== exp_seg) begin
                fails++;
                $display("FAIL load cyc=%0d: digit=%b seg=%b, required digit=%b seg=%b",
                         cyc, digit, seg, exp_dig, exp_seg);
            end
        end
        $display("[TB] load 12AF checked through cyc %0d", cyc);
    endtask

    task automatic test_bypass();
        int d;
        logic [15:0] exp_val;
        logic [3:0]  exp_dig, nib;
        logic [6:0]  exp_seg;
        value = 16'h0000; load = 1'b1;
        for (int n = 0; n < 32; n++) begin
            tick();
            load = 1'b0;
            exp_val = (cyc < 80) ? 16'h12AF : 16'h1234;
            d = (cyc / 4) % 4;
            nib = 4'(exp_val >> (4 * d));
            exp_dig = ~(4'b0001 << d);
            exp_seg = SEG_TAB[nib];
            tests++;
            if (digit !== exp_dig || seg !== exp_seg) begin
                fails++;
                $display("FAIL bypass cyc=%0d: digit=%b seg=%b, required digit=%b seg=%b",
                         cyc, digit, seg, exp_dig, exp_seg);
            end
            if (cyc == 78) begin
                value = 16'h1234; load = 1'b1;
            end
        end
        $display("[TB] boundary bypass checked through cyc %0d", cyc);
    endtask

    task automatic test_blank();
        int d;
        logic [15:0] exp_val;
        logic [3:0]  exp_dig, nib, mask;
        logic [6:0]  exp_seg;
        blank_lz = 1'b1; value = 16'h0050; load = 1'b1;
        for (int n = 0; n < 64; n++) begin
            tick();
            load = 1'b0;
            if (cyc < 112) begin
                exp_val = 16'h1234; mask = 4'b0000;
            end else if (cyc < 144) begin
                exp_val = 16'h0050; mask = 4'b1100;
            end else begin
                exp_val = 16'h0000; mask = 4'b1110;
            end
            d = (cyc / 4) % 4;
            nib = 4'(exp_val >> (4 * d));
            exp_dig = mask[d] ? 4'b1111 : ~(4'b0001 << d);
            exp_seg = mask[d] ? 7'b1111111 : SEG_TAB[nib];
            tests++;
            if (digit !== exp_dig || seg !== exp_seg) begin
                fails++;
                $display("FAIL blank cyc=%0d: digit=%b seg=%b, required digit=%b seg=%b",
                         cyc, digit, seg, exp_dig, exp_seg);
            end
            if (cyc == 127) begin
                value = 16'h0000; load = 1'b1;
            end
        end
        blank_lz = 1'b0;
        $display("[TB] leading-zero blanking checked through cyc %0d", cyc);
    endtask

    task automatic test_enable();
        int d;
        logic [3:0] exp_dig;
        logic [6:0] exp_seg;
        for (int n = 0; n < 32; n++) begin
            tick();
            d = (cyc / 4) % 4;
            if (cyc >= 166 && cyc <= 175) begin
                exp_dig = 4'b1111; exp_seg = 7'b1111111;
            end else begin
                exp_dig = ~(4'b0001 << d); exp_seg = 7'b0000001;
            end
            tests++;
            if (digit !== exp_dig || seg !== exp_seg || frame_tick !== (cyc % 16 == 0)) begin
                fails++;
                $display("FAIL enable cyc=%0d: digit=%b seg=%b tick=%b, required digit=%b seg=%b tick=%b",
                         cyc, digit, seg, frame_tick, exp_dig, exp_seg, (cyc % 16 == 0));
            end
            if (cyc == 165) enable = 1'b0;
            if (cyc == 175) enable = 1'b1;
        end
        $display("[TB] enable gating checked through cyc %0d", cyc);
    endtask

    task automatic test_rst_mid();
        int d;
        logic [3:0] exp_dig;
        logic       exp_dp;
        value = 16'h1234; load = 1'b1;
`ifdef SEVSEG_DP_EN
        dp_in = 4'b1111;
`endif
        while (cyc < 201) begin
            tick();
            load = 1'b0;
        end
        rst = 1'b1;
        tick();
        tests++;
        if (seg !== 7'b1111111 || digit !== 4'b1111 || frame_tick !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid: seg=%b digit=%b tick=%b, required seg=1111111 digit=1111 tick=0",
                     seg, digit, frame_tick);
        end
`ifdef SEVSEG_DP_EN
        tests++;
        if (dp !== 1'b1) begin
            fails++;
            $display("FAIL rst_mid_dp: dp=%b, required 1", dp);
        end
`endif
        rst = 1'b0;
        cyc = -1;
        for (int n = 0; n < 32; n++) begin
            tick();
            load = 1'b0;
            d = (cyc / 4) % 4;
            exp_dig = ~(4'b0001 << d);
            tests++;
            if (digit !== exp_dig || seg !== 7'b0000001 || frame_tick !== (cyc % 16 == 0)) begin
                fails++;
                $display("FAIL post_rst cyc=%0d: digit=%b seg=%b tick=%b, required digit=%b seg=0000001 tick=%b",
                         cyc, digit, seg, frame_tick, exp_dig, (cyc % 16 == 0));
            end
            exp_dp = !(cyc >= 16 && d == 1);
`ifdef SEVSEG_DP_EN
            tests++;
            if (dp !== exp_dp) begin
                fails++;
                $display("FAIL post_rst_dp cyc=%0d: dp=%b, required %b", cyc, dp, exp_dp);
            end
            if (cyc == 3) begin
                value = 16'h0000; dp_in = 4'b0010; load = 1'b1;
            end
`endif
        end
        $display("[TB] mid-scan reset checked through cyc %0d (last dp expectation %b)", cyc, exp_dp);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_scan();
        test_load();
        test_bypass();
        test_blank();
        test_enable();
        test_rst_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
